// File: rtl/button_onchip_memory_copier.sv
// button_onchip_memory_copier: copy or fill a block of words in an attached on-chip memory
module button_onchip_memory_copier #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W:0]   length,
  input  logic [DATA_W-1:0] fill_data,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   words_done,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W/8-1:0] byteenable,
  output logic              chipselect,
  output logic              write,
  output logic [DATA_W-1:0] writedata,
  input  logic [DATA_W-1:0] readdata,
  output logic              clken
);
  typedef enum logic [2:0] {IDLE, RD, CAP, WR, FIN} state_t;
  localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};
  state_t state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d, address_q, address_d;
  logic [ADDR_W:0] len_q, len_d, words_done_q, words_done_d;
  logic [DATA_W-1:0] fill_q, fill_d, writedata_q, writedata_d;
  logic mode_q, mode_d, abort_q, abort_d, busy_q, busy_d, done_q, done_d;
  logic chipselect_q, chipselect_d, write_q, write_d, last;
  // next state, command latches and registered bus strobes derived from the next state
  always_comb begin
    state_d = state_q;
    src_d = src_q;
    dst_d = dst_q;
    len_d = len_q;
    mode_d = mode_q;
    fill_d = fill_q;
    words_done_d = words_done_q;
    last = (words_done_q + ONE == len_q) || abort_q || abort;
    unique case (state_q)
      IDLE: if (start) begin
        mode_d = mode;
        src_d = src_addr;
        dst_d = dst_addr;
        len_d = length;
        fill_d = fill_data;
        words_done_d = '0;
        state_d = (length == '0) ? FIN : mode ? WR : RD;
      end
      RD: state_d = CAP;
      CAP: state_d = WR;
      WR: begin
        words_done_d = words_done_q + ONE;
        src_d = src_q + ONE[ADDR_W-1:0];
        dst_d = dst_q + ONE[ADDR_W-1:0];
        state_d = last ? FIN : mode_q ? WR : RD;
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    abort_d = (state_q != IDLE) && (state_d != IDLE) && (abort_q || abort);
    busy_d = (state_d == RD) || (state_d == CAP) || (state_d == WR);
    done_d = state_d == FIN;
    chipselect_d = (state_d == RD) || (state_d == WR);
    write_d = state_d == WR;
    address_d = (state_d == RD) ? src_d : (state_d == WR) ? dst_d : address_q;
    writedata_d = (state_d == WR) ? (mode_d ? fill_d : readdata) : writedata_q;
  end
  // state and output registers with asynchronous clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      src_q <= '0;
      dst_q <= '0;
      len_q <= '0;
      mode_q <= 1'b0;
      fill_q <= '0;
      words_done_q <= '0;
      abort_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      chipselect_q <= 1'b0;
      write_q <= 1'b0;
      address_q <= '0;
      writedata_q <= '0;
    end else begin
      state_q <= state_d;
      src_q <= src_d;
      dst_q <= dst_d;
      len_q <= len_d;
      mode_q <= mode_d;
      fill_q <= fill_d;
      words_done_q <= words_done_d;
      abort_q <= abort_d;
      busy_q <= busy_d;
      done_q <= done_d;
      chipselect_q <= chipselect_d;
      write_q <= write_d;
      address_q <= address_d;
      writedata_q <= writedata_d;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign words_done = words_done_q;
  assign address = address_q;
  assign byteenable = '1;
  assign chipselect = chipselect_q;
  assign write = write_q;
  assign writedata = writedata_q;
  assign clken = 1'b1;
endmodule
